// File: rtl/inst_cache_pkg.sv
// inst_cache_pkg: shared FSM encoding, default geometry and miss filler for the instruction cache.
package inst_cache_pkg;
   typedef enum logic {IDLE = 1'b0, REFILL = 1'b1} state_e;
   localparam int LINES_DEF = 16;
   localparam int WORDS_DEF = 4;
   // addi x0,x0,0: harmless if the fetch stage ever latches a non-hit cycle
   localparam logic [31:0] INST_FLUSH = 32'h0000_0013;
endpackage

// File: rtl/inst_cache_if.sv
// inst_cache_if: fetch-side and backing-memory signals of the instruction cache.
interface inst_cache_if;
   logic        inst_ce_i;
   logic [31:0] inst_addr_i;
   logic        flush_i;
   logic [31:0] inst_o;
   logic        inst_valid_o;
   logic        cache_stall_o;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_ack_i;
   logic [31:0] mem_data_i;
   modport slave (
      input  inst_ce_i, inst_addr_i, flush_i, mem_ack_i, mem_data_i,
      output inst_o, inst_valid_o, cache_stall_o, mem_req_o, mem_addr_o
   );
   modport master (
      output inst_ce_i, inst_addr_i, flush_i, mem_ack_i, mem_data_i,
      input  inst_o, inst_valid_o, cache_stall_o, mem_req_o, mem_addr_o
   );
endinterface

// File: rtl/icache_refill_fsm.sv
// icache_refill_fsm: IDLE/REFILL sequencer that fetches one line word by word over req/ack.
module icache_refill_fsm
   import inst_cache_pkg::*;
#(
   parameter int WORDS = WORDS_DEF,
   localparam int OFF = $clog2(WORDS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic [29-OFF:0] line_i,
   input  logic            flush_i,
   input  logic            mem_ack_i,
   output logic            mem_req_o,
   output logic [31:0]     mem_addr_o,
   output logic            busy_o,
   output logic            we_o,
   output logic            done_o,
   output logic            fill_valid_o,
   output logic [OFF-1:0]  cnt_o,
   output logic [29-OFF:0] line_o
);
   state_e          state_q, state_d;
   logic [OFF-1:0]  cnt_q, cnt_d;
   logic [29-OFF:0] base_q, base_d;
   logic            kill_q, kill_d;

   always_ff @(posedge clk)
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         base_q  <= '0;
         kill_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         base_q  <= base_d;
         kill_q  <= kill_d;
      end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      base_d  = base_q;
      kill_d  = kill_q;
      if (state_q == IDLE) begin
         if (start_i) begin
            state_d = REFILL;
            cnt_d   = '0;
            base_d  = line_i;
            kill_d  = 1'b0;
         end
      end else begin
         if (flush_i) kill_d = 1'b1;
         if (mem_ack_i) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == OFF'(WORDS - 1)) state_d = IDLE;
         end
      end
   end

   // a flush landing on the final ack must also leave the line invalid
   always_comb begin
      mem_req_o    = state_q == REFILL;
      mem_addr_o   = {base_q, cnt_q, 2'b00};
      busy_o       = state_q != IDLE;
      we_o         = mem_req_o && mem_ack_i;
      done_o       = we_o && cnt_q == OFF'(WORDS - 1);
      fill_valid_o = !kill_q && !flush_i;
      cnt_o        = cnt_q;
      line_o       = base_q;
   end
endmodule

// File: rtl/inst_cache.sv
// inst_cache: direct-mapped instruction cache, combinational hits, req/ack line refill on miss.
// Defining ICACHE_STATS_EN adds saturating hit/miss counters on hit_cnt_o/miss_cnt_o.
module inst_cache
   import inst_cache_pkg::*;
#(
   parameter int LINES = LINES_DEF,
   parameter int WORDS = WORDS_DEF
) (
   input logic clk,
   input logic rst,
   inst_cache_if.slave bus
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0] hit_cnt_o,
   output logic [31:0] miss_cnt_o
`endif
);
   localparam int OFF = $clog2(WORDS);
   localparam int IDX = $clog2(LINES);
   localparam int TAG = 30 - OFF - IDX;

   logic [LINES-1:0] valid_q;
   logic [TAG-1:0]   tag_q [LINES];
   logic [31:0]      data_q [LINES][WORDS];
   logic [OFF-1:0]   off, cnt;
   logic [IDX-1:0]   idx, fidx;
   logic [TAG-1:0]   tag;
   logic [29-OFF:0]  line;
   logic             hit, busy, start, we, done, fill_valid;
   logic             unused_addr;

   assign unused_addr = ^bus.inst_addr_i[1:0];
   assign off   = bus.inst_addr_i[OFF+1:2];
   assign idx   = bus.inst_addr_i[OFF+IDX+1:OFF+2];
   assign tag   = bus.inst_addr_i[31:OFF+IDX+2];
   assign fidx  = line[IDX-1:0];
   assign hit   = valid_q[idx] && tag_q[idx] == tag;
   assign start = bus.inst_ce_i && !hit && !busy;

   assign bus.inst_valid_o  = bus.inst_ce_i && hit && !busy;
   assign bus.cache_stall_o = busy || (bus.inst_ce_i && !hit);
   assign bus.inst_o        = bus.inst_valid_o ? data_q[idx][off] : INST_FLUSH;

   icache_refill_fsm #(.WORDS(WORDS)) u_fsm (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start),
      .line_i       (bus.inst_addr_i[31:OFF+2]),
      .flush_i      (bus.flush_i),
      .mem_ack_i    (bus.mem_ack_i),
      .mem_req_o    (bus.mem_req_o),
      .mem_addr_o   (bus.mem_addr_o),
      .busy_o       (busy),
      .we_o         (we),
      .done_o       (done),
      .fill_valid_o (fill_valid),
      .cnt_o        (cnt),
      .line_o       (line)
   );

   // the fill write comes last so it wins over a same-cycle flush clear
   always_ff @(posedge clk)
      if (!rst) valid_q <= '0;
      else begin
         if (bus.flush_i) valid_q <= '0;
         if (done) valid_q[fidx] <= fill_valid;
      end

   always_ff @(posedge clk)
      if (rst && we) begin
         data_q[fidx][cnt] <= bus.mem_data_i;
         if (done) tag_q[fidx] <= line[29-OFF:IDX];
      end

`ifdef ICACHE_STATS_EN
   logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

   always_comb begin
      hit_cnt_d  = bus.inst_valid_o && ~&hit_cnt_q ? hit_cnt_q + 32'd1 : hit_cnt_q;
      miss_cnt_d = start && ~&miss_cnt_q ? miss_cnt_q + 32'd1 : miss_cnt_q;
   end

   always_ff @(posedge clk)
      if (!rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end

   assign hit_cnt_o  = hit_cnt_q;
   assign miss_cnt_o = miss_cnt_q;
`endif
endmodule

// File: tb/tb_inst_cache.sv
// tb_inst_cache: randomized fetches against a line-level cache model, scoreboard checked by a monitor.
module tb_inst_cache;
   import inst_cache_pkg::*;
   localparam int LINES = LINES_DEF;
   localparam int WORDS = WORDS_DEF;
   localparam int OFF = $clog2(WORDS);
   localparam int IDX = $clog2(LINES);

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          stall;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   inst_cache_if bus();
`ifdef ICACHE_STATS_EN
   logic [31:0] hit_cnt, miss_cnt;
`endif

   inst_cache dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef ICACHE_STATS_EN
      ,
      .hit_cnt_o  (hit_cnt),
      .miss_cnt_o (miss_cnt)
`endif
   );

   always #5 clk = ~clk;

   exp_t        sb_q[$];
   logic [31:0] addr_q[$];
   int          vectors = 0;
   int          errors = 0;
   int          w = 0;
   logic        stray = 1'b0;
   bit          mv[LINES];
   int unsigned mt[LINES];

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return {2'b00, a[31:2]} + 32'h60;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic finish_run();
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d expected fetches never returned", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   endtask

   // backing memory: w wait cycles before each ack, checks the requested word address
   initial begin
      int wc = 0;
      bus.mem_ack_i  = 1'b0;
      bus.mem_data_i = '0;
      forever begin
         @(posedge clk);
         #1;
         if (bus.mem_req_o) begin
            if (addr_q.size() == 0) begin
               errors++;
               $display("FAIL mem_req_unexpected: got addr %h, expected no request", bus.mem_addr_o);
               bus.mem_ack_i = 1'b0;
            end else if (wc == w) begin
               check("mem_addr", bus.mem_addr_o, addr_q.pop_front());
               bus.mem_ack_i  = 1'b1;
               bus.mem_data_i = mem_fn(bus.mem_addr_o);
               wc = 0;
            end else begin
               check("mem_addr_hold", bus.mem_addr_o, addr_q[0]);
               bus.mem_ack_i = 1'b0;
               wc++;
            end
         end else begin
            bus.mem_ack_i  = stray;
            bus.mem_data_i = 32'hDEAD_BEEF;
            wc = 0;
         end
      end
   end

   // monitor: counts stalled fetch cycles and checks each returned instruction
   initial begin
      int st = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) st = 0;
         else if (bus.inst_ce_i && bus.cache_stall_o) begin
            st++;
            check("inst_o_on_miss", bus.inst_o, INST_FLUSH);
         end
         if (bus.inst_valid_o) begin
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL hit_unexpected: got inst %h, expected no fetch outstanding", bus.inst_o);
            end else begin
               e = sb_q.pop_front();
               check($sformatf("inst@%h", e.addr), bus.inst_o, e.data);
               check($sformatf("stall@%h", e.addr), 32'(st), 32'(e.stall));
            end
            st = 0;
         end
      end
   end

   task automatic fetch(input logic [31:0] a, input int flush_ack);
      int unsigned ix, tg;
      int n_ref, cyc, acks;
      exp_t e;
      ix = (a >> (2 + OFF)) % LINES;
      tg = a >> (2 + OFF + IDX);
      n_ref = (mv[ix] && mt[ix] == tg) ? 0 : (flush_ack != 0 ? 2 : 1);
      for (int r = 0; r < n_ref; r++)
         for (int k = 0; k < WORDS; k++)
            addr_q.push_back(((a >> (2 + OFF)) << (2 + OFF)) + 32'(4 * k));
      e.addr  = a;
      e.data  = mem_fn(a);
      e.stall = n_ref * (WORDS + 1 + WORDS * w);
      sb_q.push_back(e);
      bus.inst_ce_i   = 1'b1;
      bus.inst_addr_i = a;
      acks = 0;
      cyc  = 0;
      forever begin
         @(negedge clk);
         bus.flush_i = 1'b0;
         if (bus.mem_ack_i) begin
            acks++;
            if (acks == flush_ack) bus.flush_i = 1'b1;
         end
         if (bus.inst_valid_o) break;
         if (++cyc > 500) begin
            errors++;
            $display("FAIL fetch_timeout: addr %h got no hit in 500 cycles, expected one", a);
            finish_run();
         end
      end
      @(posedge clk);
      #1;
      bus.inst_ce_i = 1'b0;
      bus.flush_i   = 1'b0;
      if (flush_ack != 0 && n_ref != 0) mv = '{default: 0};
      mv[ix] = 1'b1;
      mt[ix] = tg;
   endtask

   initial begin
      logic [31:0] a;
      bus.inst_ce_i   = 1'b0;
      bus.inst_addr_i = '0;
      bus.flush_i     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check("rst_mem_req", 32'(bus.mem_req_o), 0);
      check("rst_mem_addr", bus.mem_addr_o, 0);
      check("rst_stall", 32'(bus.cache_stall_o), 0);
      check("rst_valid", 32'(bus.inst_valid_o), 0);
      check("rst_inst", bus.inst_o, INST_FLUSH);
      @(posedge clk);
      #1;
      fetch(32'h100, 0);
      fetch(32'h104, 0);
      fetch(32'h10C, 0);
      fetch(32'h100, 0);
      fetch(32'h200, 0);
      fetch(32'h100, 0);
      w = 2;
      fetch(32'h300, 0);
      w = 0;
      fetch(32'h100, 2);
      fetch(32'h104, 0);
      // reset during a refill, then a stray ack while idle
      addr_q.delete();
      for (int k = 0; k < WORDS; k++) addr_q.push_back(32'h200 + 32'(4 * k));
      bus.inst_ce_i   = 1'b1;
      bus.inst_addr_i = 32'h200;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (bus.mem_ack_i) break;
      end
      check("first_ack_seen", 32'(bus.mem_ack_i), 1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.inst_ce_i = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      check("midrst_mem_req", 32'(bus.mem_req_o), 0);
      check("midrst_mem_addr", bus.mem_addr_o, 0);
      check("midrst_stall", 32'(bus.cache_stall_o), 0);
      @(negedge clk);
      stray = 1'b1;
      @(negedge clk);
      stray = 1'b0;
      check("stray_mem_req", 32'(bus.mem_req_o), 0);
      @(negedge clk);
      check("stray_mem_req_after", 32'(bus.mem_req_o), 0);
      check("stray_mem_addr", bus.mem_addr_o, 0);
      addr_q.delete();
      mv = '{default: 0};
      @(posedge clk);
      #1;
      fetch(32'h100, 0);
      for (int i = 0; i < 150; i++) begin
         w = $urandom_range(0, 2);
         a = (32'($urandom_range(0, 3)) << (2 + OFF + IDX))
           | (32'($urandom_range(0, LINES - 1)) << (2 + OFF))
           | (32'($urandom_range(0, WORDS - 1)) << 2)
           | 32'($urandom_range(0, 3));
         fetch(a, 0);
         if ($urandom_range(0, 7) == 0) begin
            bus.flush_i = 1'b1;
            @(posedge clk);
            #1;
            bus.flush_i = 1'b0;
            mv = '{default: 0};
         end
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
      end
      repeat (3) @(posedge clk);
      finish_run();
   end
endmodule

// File: doc/inst_cache.md
# inst_cache

Direct-mapped instruction cache that answers the fetch stage's instruction-memory port (`inst_ce`/`inst_addr` → `inst`) and refills lines from a slower backing memory over a req/ack handshake. Hits return the instruction combinationally in the same cycle the address is presented. Misses raise `cache_stall_o` to the hazard unit, which holds `pc_stall`/`if_stall` until the refill FSM installs the line.

## Interface
- `LINES`, 16: number of lines; power of two.
- `WORDS`, 4: 32-bit words per line; power of two, at least 2.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-low reset.
- `inst_ce_i`  in  1: fetch request valid; when low, no lookup and no miss.
- `inst_addr_i`  in  32: fetch byte address; bits [1:0] ignored.
- `flush_i`  in  1: invalidate all lines (fence.i); single-cycle pulse.
- `inst_o`  out  32: instruction on hit, else `` `INST_FLUSH ``.
- `inst_valid_o`  out  1: hit qualifier, `inst_ce_i & hit & state==IDLE`.
- `cache_stall_o`  out  1: `inst_ce_i & !hit` in IDLE, or state != IDLE.
- `mem_req_o`  out  1: backing-memory read request.
- `mem_addr_o`  out  32: word-aligned read address; stable while `mem_req_o` is high and no ack has arrived.
- `mem_ack_i`  in  1: read data valid this cycle.
- `mem_data_i`  in  32: read data, sampled when `mem_ack_i` is high.

## Operation
- Address split: offset = `addr[2+OFF-1:2]` (OFF = log2 WORDS), index = next log2 LINES bits, tag = the remaining upper bits.
- Storage per line: valid bit, tag, and WORDS data words in register arrays. Hit = `valid[index] & tag match`.
- FSM states: IDLE and REFILL.
  - **IDLE:** on `inst_ce_i & !hit`, latch the line base address (offset bits zeroed), clear the word counter and the kill flag, then go to REFILL. `mem_req_o` is 0 in IDLE.
  - **REFILL:** `mem_req_o`=1 and `mem_addr_o` = base + 4·counter. On each `mem_ack_i`:
    - write `mem_data_i` into the word at the counter;
    - increment the counter.
    - On the ack for word WORDS-1, write the tag, set valid = !kill (including a flush arriving in that same cycle), and return to IDLE.
  - `mem_req_o` stays high across consecutive words. The address advances the cycle after each ack.
- `flush_i` in IDLE clears every valid bit at the next edge. If a lookup coincides with the flush, it uses the pre-flush state.
- `flush_i` in REFILL clears all valid bits and sets kill. The refill runs to completion, but the line is left invalid, so the next lookup misses again.
- Changes on `inst_addr_i` or `inst_ce_i` during REFILL have no effect; the refill uses the latched base.
- `mem_ack_i` while `mem_req_o` is 0 is ignored.

## Timing
- Reset values:
  - all valid bits 0;
  - state IDLE;
  - `mem_req_o` 0;
  - `mem_addr_o` 0;
  - counter 0;
  - kill 0.
- Data/tag arrays are not reset. `inst_o`/`inst_valid_o`/`cache_stall_o` follow combinationally from the cleared state.
- Hit latency: 0 cycles. The fetch stage registers `inst_o` at the same edge.
- Miss detected in cycle t: `cache_stall_o` is high in cycle t, and `mem_req_o` rises in cycle t+1.
- With a zero-wait memory (ack in every REFILL cycle), the acks land in t+1…t+WORDS. The line is valid from t+WORDS+1, where `cache_stall_o` falls and the hit returns. Each memory wait cycle adds one.
- Reset asserted mid-refill: back to IDLE and `mem_req_o` 0 at the next edge. The partial line stays invalid.

## Configuration
- `ICACHE_STATS_EN` defined:
  - adds outputs `hit_cnt_o` [31:0] and `miss_cnt_o` [31:0];
  - `hit_cnt_o` increments on each cycle with `inst_valid_o`;
  - `miss_cnt_o` increments on each IDLE→REFILL transition;
  - both reset to 0 and saturate at 0xFFFFFFFF.
- Undefined: neither port nor the counters exist.

## Structure
- Shared package/include (alongside `INST_OPCODE.v`):
  - the FSM state encodings;
  - the default `LINES`/`WORDS`;
  - `` `INST_FLUSH `` as the miss filler.
- One natural sub-module, `icache_refill_fsm`: state, counter, kill flag, and the memory handshake.
- Arrays and lookup logic stay in `inst_cache`.

## Test plan
- **Cold miss then hit:**
  - Stimulus: after reset, `inst_ce_i`=1 at addr 0x100, memory zero-wait returning 0xA0..0xA3.
  - Response: stall for 5 cycles; `mem_addr_o` 0x100, 0x104, 0x108, 0x10C; then `inst_o`=0xA0 with `inst_valid_o`=1 and stall 0.
- **Same-line hits:** addrs 0x104, 0x10C after the fill → `inst_o` 0xA1, 0xA3 with zero stall cycles and no `mem_req_o`.
- **Conflict eviction:** fetch 0x100, then 0x200 (same index with defaults) → refill; then 0x100 misses again.
- **Wait states:** ack delayed 2 cycles per word → `mem_addr_o` held stable until each ack; stall lasts 13 cycles.
- **Flush during refill:** `flush_i` pulsed on the 2nd ack → refill completes; the following lookup of 0x100 misses and refills again.
- **Reset mid-refill:** `rst`=0 after the 1st ack → next cycle `mem_req_o`=0 and state IDLE; a stray `mem_ack_i` is ignored; 0x100 still misses.
